// File: rtl/i2s_fifo_write_arbiter_pkg.sv
// Shared channel type and round-robin helper for the I2S FIFO write arbiter.
package i2s_pkg;

  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_e;

  // On a tie the channel that did not win last time gets the port.
  function automatic i2s_ch_e next_rr(i2s_ch_e last);
    return (last == CH_LEFT) ? CH_RIGHT : CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_fifo_write_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, then increment unless already all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/i2s_fifo_write_arbiter.sv
// Shares the sample FIFO write port between the left and right I2S channels.
// Each channel owns a one-entry holding slot; a round-robin grant drains one
// slot per cycle whenever the FIFO has room.
module i2s_fifo_write_arbiter
  import i2s_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 left_valid_i,
  input  logic [WIDTH-1:0]     left_data_i,
  input  logic                 right_valid_i,
  input  logic [WIDTH-1:0]     right_data_i,
  input  logic                 fifo_full_i,
  output logic                 fifo_wr_en_o,
  output logic [WIDTH:0]       fifo_data_o,
  output logic [CNT_WIDTH-1:0] left_ovf_o,
  output logic [CNT_WIDTH-1:0] right_ovf_o,
  output logic                 busy_o
);

  logic             pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  i2s_ch_e          last_grant_q, last_grant_d;
  i2s_ch_e          grant_ch;
  logic             grant_v, grant_l, grant_r;
  logic             cap_l, cap_r, drop_l, drop_r;

  // Grant: nothing while full; a lone pending slot wins; ties go round-robin.
  // With no grant, grant_ch rests on last_grant so the data bus stays stable.
  always_comb begin
    grant_v  = 1'b0;
    grant_ch = last_grant_q;
    if (!fifo_full_i) begin
      if (pend_l_q && pend_r_q) begin
        grant_v  = 1'b1;
        grant_ch = next_rr(last_grant_q);
      end else if (pend_l_q) begin
        grant_v  = 1'b1;
        grant_ch = CH_LEFT;
      end else if (pend_r_q) begin
        grant_v  = 1'b1;
        grant_ch = CH_RIGHT;
      end
    end
  end

  assign grant_l = grant_v && (grant_ch == CH_LEFT);
  assign grant_r = grant_v && (grant_ch == CH_RIGHT);
  assign cap_l   = left_valid_i && enable_i;
  assign cap_r   = right_valid_i && enable_i;

  // Slot next-state: capture into a free or draining slot, else drop and count.
  always_comb begin
    pend_l_d     = pend_l_q;
    hold_l_d     = hold_l_q;
    drop_l       = 1'b0;
    pend_r_d     = pend_r_q;
    hold_r_d     = hold_r_q;
    drop_r       = 1'b0;
    last_grant_d = grant_v ? grant_ch : last_grant_q;
    if (cap_l) begin
      if (!pend_l_q || grant_l) begin
        hold_l_d = left_data_i;
        pend_l_d = 1'b1;
      end else begin
        drop_l = 1'b1;
      end
    end else if (grant_l) begin
      pend_l_d = 1'b0;
    end
    if (cap_r) begin
      if (!pend_r_q || grant_r) begin
        hold_r_d = right_data_i;
        pend_r_d = 1'b1;
      end else begin
        drop_r = 1'b1;
      end
    end else if (grant_r) begin
      pend_r_d = 1'b0;
    end
  end

  // Slot and arbitration state; reset leaves last_grant on right so left wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_l_q     <= 1'b0;
      hold_l_q     <= '0;
      pend_r_q     <= 1'b0;
      hold_r_q     <= '0;
      last_grant_q <= CH_RIGHT;
    end else begin
      pend_l_q     <= pend_l_d;
      hold_l_q     <= hold_l_d;
      pend_r_q     <= pend_r_d;
      hold_r_q     <= hold_r_d;
      last_grant_q <= last_grant_d;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_ovf_left (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (drop_l),
    .clr_i   (clear_i),
    .count_o (left_ovf_o)
  );

  sat_counter #(.W(CNT_WIDTH)) u_ovf_right (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (drop_r),
    .clr_i   (clear_i),
    .count_o (right_ovf_o)
  );

  assign fifo_wr_en_o = grant_v;
  assign fifo_data_o  = {grant_ch == CH_RIGHT, (grant_ch == CH_RIGHT) ? hold_r_q : hold_l_q};
  assign busy_o       = pend_l_q | pend_r_q;

endmodule

// File: tb/tb_i2s_fifo_write_arbiter.sv
// Directed bench for i2s_fifo_write_arbiter: inputs change and outputs are
// sampled on the falling edge, away from the rising capture edge.
module tb_i2s_fifo_write_arbiter;

  localparam int WIDTH     = 24;
  localparam int CNT_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable_i = 1'b1;
  logic                 clear_i = 1'b0;
  logic                 left_valid_i = 1'b0;
  logic [WIDTH-1:0]     left_data_i = '0;
  logic                 right_valid_i = 1'b0;
  logic [WIDTH-1:0]     right_data_i = '0;
  logic                 fifo_full_i = 1'b0;
  logic                 fifo_wr_en_o;
  logic [WIDTH:0]       fifo_data_o;
  logic [CNT_WIDTH-1:0] left_ovf_o;
  logic [CNT_WIDTH-1:0] right_ovf_o;
  logic                 busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2s_fifo_write_arbiter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .clear_i       (clear_i),
    .left_valid_i  (left_valid_i),
    .left_data_i   (left_data_i),
    .right_valid_i (right_valid_i),
    .right_data_i  (right_data_i),
    .fifo_full_i   (fifo_full_i),
    .fifo_wr_en_o  (fifo_wr_en_o),
    .fifo_data_o   (fifo_data_o),
    .left_ovf_o    (left_ovf_o),
    .right_ovf_o   (right_ovf_o),
    .busy_o        (busy_o)
  );

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    left_valid_i = 1'b0; right_valid_i = 1'b0;
    fifo_full_i = 1'b0; clear_i = 1'b0; enable_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (fifo_wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0b exp=0", fifo_wr_en_o); end
    checks++;
    if (fifo_data_o !== 25'h1000000) begin failures++; $display("FAIL reset_data got=%h exp=1000000", fifo_data_o); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    checks++;
    if (left_ovf_o !== 8'd0 || right_ovf_o !== 8'd0) begin
      failures++; $display("FAIL reset_ovf got=%0d/%0d exp=0/0", left_ovf_o, right_ovf_o);
    end
  endtask

  task automatic test_single_left();
    reset_dut();
    left_valid_i = 1'b1; left_data_i = 24'h123456;
    @(negedge clk);
    left_valid_i = 1'b0;
    checks++;
    if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 25'h0123456) begin
      failures++; $display("FAIL single_write got=%0b/%h exp=1/0123456", fifo_wr_en_o, fifo_data_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || fifo_wr_en_o !== 1'b0) begin
      failures++; $display("FAIL single_drain got busy=%0b wr=%0b exp=0/0", busy_o, fifo_wr_en_o);
    end
  endtask

  task automatic test_both_same_cycle();
    reset_dut();
    left_valid_i = 1'b1; left_data_i = 24'hAAAAAA;
    right_valid_i = 1'b1; right_data_i = 24'h555555;
    @(negedge clk);
    left_valid_i = 1'b0; right_valid_i = 1'b0;
    checks++;
    if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 25'h0AAAAAA) begin
      failures++; $display("FAIL both_first got=%0b/%h exp=1/0AAAAAA", fifo_wr_en_o, fifo_data_o);
    end
    @(negedge clk);
    checks++;
    if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 25'h1555555) begin
      failures++; $display("FAIL both_second got=%0b/%h exp=1/1555555", fifo_wr_en_o, fifo_data_o);
    end
    @(negedge clk);
    checks++;
    if (fifo_wr_en_o !== 1'b0 || busy_o !== 1'b0 || left_ovf_o !== 8'd0 || right_ovf_o !== 8'd0) begin
      failures++; $display("FAIL both_idle got wr=%0b busy=%0b ovf=%0d/%0d exp=0/0/0/0",
                           fifo_wr_en_o, busy_o, left_ovf_o, right_ovf_o);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    fifo_full_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      left_valid_i = 1'b1; left_data_i = WIDTH'(i);
      @(negedge clk);
      checks++;
      if (fifo_wr_en_o !== 1'b0) begin failures++; $display("FAIL full_no_write step=%0d got=%0b exp=0", i, fifo_wr_en_o); end
    end
    left_valid_i = 1'b0;
    checks++;
    if (left_ovf_o !== 8'd2 || busy_o !== 1'b1) begin
      failures++; $display("FAIL full_ovf got ovf=%0d busy=%0b exp=2/1", left_ovf_o, busy_o);
    end
    fifo_full_i = 1'b0;
    #1;
    checks++;
    if (fifo_wr_en_o !== 1'b1 || fifo_data_o !== 25'h0000001) begin
      failures++; $display("FAIL full_release got=%0b/%h exp=1/0000001", fifo_wr_en_o, fifo_data_o);
    end
    // Right channel drops count independently.
    fifo_full_i = 1'b1;
    @(negedge clk);
    right_valid_i = 1'b1; right_data_i = 24'h0000AB;
    @(negedge clk);
    @(negedge clk);
    right_valid_i = 1'b0;
    checks++;
    if (right_ovf_o !== 8'd1 || left_ovf_o !== 8'd2) begin
      failures++; $display("FAIL right_ovf got=%0d/%0d exp=2/1 (left/right)", left_ovf_o, right_ovf_o);
    end
    fifo_full_i = 1'b0;
  endtask

  task automatic test_saturate_clear();
    reset_dut();
    fifo_full_i = 1'b1;
    left_valid_i = 1'b1; left_data_i = 24'h00BEEF;
    for (int i = 0; i < 300; i++) @(negedge clk);
    checks++;
    if (left_ovf_o !== 8'd255) begin failures++; $display("FAIL saturate got=%0d exp=255", left_ovf_o); end
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; left_valid_i = 1'b0;
    checks++;
    if (left_ovf_o !== 8'd0) begin failures++; $display("FAIL clear_vs_inc got=%0d exp=0", left_ovf_o); end
    // Disabled pulses are neither captured nor counted.
    enable_i = 1'b0; left_valid_i = 1'b1;
    @(negedge clk);
    left_valid_i = 1'b0; enable_i = 1'b1;
    checks++;
    if (left_ovf_o !== 8'd0) begin failures++; $display("FAIL disabled_count got=%0d exp=0", left_ovf_o); end
    fifo_full_i = 1'b0;
    #1;
    checks++;
    if (fifo_data_o !== 25'h000BEEF) begin failures++; $display("FAIL disabled_keep got=%h exp=000BEEF", fifo_data_o); end
  endtask

  task automatic test_back_to_back();
    int writes;
    int bad;
    reset_dut();
    writes = 0;
    bad = 0;
    for (int cyc = 0; cyc < 1006; cyc++) begin
      if (fifo_wr_en_o === 1'b1) begin
        if (fifo_data_o !== {writes[0], ((writes[0] ? 24'h800000 : 24'h000000) | 24'(writes / 2))}) begin
          bad++;
          if (bad <= 4) $display("FAIL rr_order write=%0d got=%h", writes, fifo_data_o);
        end
        writes++;
      end
      if (cyc[0] == 1'b0 && cyc < 1000) begin
        left_valid_i  = 1'b1; left_data_i  = 24'(cyc / 2);
        right_valid_i = 1'b1; right_data_i = 24'h800000 | 24'(cyc / 2);
      end else begin
        left_valid_i = 1'b0; right_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rr_sequence got bad=%0d exp=0", bad); end
    checks++;
    if (writes != 1000) begin failures++; $display("FAIL rr_count got=%0d exp=1000", writes); end
    checks++;
    if (left_ovf_o !== 8'd0 || right_ovf_o !== 8'd0) begin
      failures++; $display("FAIL rr_ovf got=%0d/%0d exp=0/0", left_ovf_o, right_ovf_o);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    fifo_full_i = 1'b1;
    left_valid_i = 1'b1; left_data_i = 24'h111111;
    right_valid_i = 1'b1; right_data_i = 24'h222222;
    @(negedge clk);
    left_valid_i = 1'b0; right_valid_i = 1'b0;
    fifo_full_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b1 || fifo_wr_en_o !== 1'b1) begin
      failures++; $display("FAIL pre_reset got busy=%0b wr=%0b exp=1/1", busy_o, fifo_wr_en_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || fifo_wr_en_o !== 1'b0 || fifo_data_o !== 25'h1000000) begin
      failures++; $display("FAIL async_reset got busy=%0b wr=%0b data=%h exp=0/0/1000000",
                           busy_o, fifo_wr_en_o, fifo_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    left_valid_i = 1'b1; left_data_i = 24'h333333;
    right_valid_i = 1'b1; right_data_i = 24'h444444;
    @(negedge clk);
    left_valid_i = 1'b0; right_valid_i = 1'b0;
    checks++;
    if (fifo_data_o !== 25'h0333333 || fifo_wr_en_o !== 1'b1) begin
      failures++; $display("FAIL first_tie got=%0b/%h exp=1/0333333", fifo_wr_en_o, fifo_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_left();
    test_both_same_cycle();
    test_backpressure();
    test_saturate_clear();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_fifo_write_arbiter.md
# i2s_fifo_write_arbiter

Shares the single write port of the sample FIFO between the left and right channel outputs of the I2S deserializer. Each channel gets a one-entry holding register. A round-robin scheduler grants the FIFO write port to one pending channel per cycle, and each channel has a saturating overflow counter for samples lost to backpressure. The block sits between the I2S receiver and the FIFO's write side; the FIFO read side is untouched.

## Interface
- `WIDTH`, default 24: sample width in bits.
- `CNT_WIDTH`, default 8: overflow counter width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  accept new samples when high.
- `clear_i`  in  1  synchronous clear of both overflow counters.
- `left_valid_i`  in  1  one-cycle pulse: `left_data_i` valid.
- `left_data_i`  in  WIDTH  left sample.
- `right_valid_i`  in  1  one-cycle pulse: `right_data_i` valid.
- `right_data_i`  in  WIDTH  right sample.
- `fifo_full_i`  in  1  FIFO full flag.
- `fifo_wr_en_o`  out  1  FIFO write enable.
- `fifo_data_o`  out  WIDTH+1  `{channel_tag, sample}`; tag 0 = left, 1 = right.
- `left_ovf_o`  out  CNT_WIDTH  left overflow count.
- `right_ovf_o`  out  CNT_WIDTH  right overflow count.
- `busy_o`  out  1  at least one holding register is pending.

## Operation
- Per-channel state: `pend` flag and `hold` register (WIDTH).
- Grant (combinational):
  - When `fifo_full_i` = 1, there is no grant.
  - When only one channel is pending, that channel is granted.
  - When both are pending, the channel other than `last_grant` is granted.
- `fifo_wr_en_o` = any grant.
- `fifo_data_o` = `{granted_ch, hold[granted_ch]}`.
  - When there is no grant, `fifo_data_o` is `{last_grant, hold[last_grant]}`. This is don't-care for the FIFO but deterministic.
- `last_grant` updates to the granted channel on every grant. It holds its value when there is no grant.
- Capture rule for a channel with `valid` = 1 and `enable_i` = 1:
  - Slot free (`pend` = 0) or granted this cycle: `hold` ← data, `pend` ← 1.
  - Slot pending and not granted: sample is dropped and that channel's overflow counter increments.
- Grant without a new capture: `pend` ← 0.
- `enable_i` = 0: valid pulses are ignored and not counted. Pending entries still drain.
- Overflow counters:
  - Saturate at all-ones.
  - `clear_i` has priority over an increment in the same cycle (result is 0).
- `busy_o` = `pend_left | pend_right`.

## Timing
- Reset values:
  - `pend` = 0 and `hold` = 0 for both channels.
  - `last_grant` = 1, so left wins the first tie.
  - Counters = 0.
  - Outputs: `fifo_wr_en_o` = 0, `fifo_data_o` = `{1'b1, 0}`, `busy_o` = 0.
- Latency: a valid pulse sampled at edge t sets `pend` after t. `fifo_wr_en_o` rises in the cycle after t. The FIFO writes at edge t+1.
- `fifo_wr_en_o` is combinational from registered `pend` and `fifo_full_i`. It is never asserted while `fifo_full_i` = 1, so the FIFO never silently discards a write.
- Throughput: one FIFO write per cycle. Sustained rate per channel is one sample per 2 cycles when both channels are active.
- Simultaneous events:
  - A grant and a new capture on the same channel in the same cycle are lossless; the new sample replaces the old.
  - Both valid pulses with both slots free: both are captured.
- Reset asserted mid-operation: all pending samples are discarded immediately (asynchronous). Counters clear.

## Structure
- Package `i2s_pkg`:
  - `typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_e`
  - `function automatic` `next_rr(i2s_ch_e last)`
- Natural sub-module: `sat_counter` (parameterised width, `inc` and `clr` inputs, `clr` priority), instantiated once per channel.
- Arbitration and holding registers stay inline.

## Test plan
- Reset, then a left pulse with `0x123456` → `fifo_wr_en_o` = 1 one cycle later with `fifo_data_o` = `0x0123456`. `busy_o` drops the following cycle.
- Left `0xAAAAAA` and right `0x555555` in the same cycle, FIFO not full → left written, then right (`0x1555555`) on the next cycle. No overflow.
- Hold `fifo_full_i` = 1, then pulse left 3 times → one sample held, `left_ovf_o` = 2. Releasing full writes the first sample.
- Hold full with a continuous left pulse beyond 255 drops (`CNT_WIDTH` = 8) → `left_ovf_o` stays at 255. A `clear_i` pulse coincident with a drop → 0.
- Both channels pulsing every 2 cycles, FIFO never full → strict L,R,L,R tag order and zero overflow over 1000 samples.
- Assert `rst` while both slots are pending → `busy_o` and `fifo_wr_en_o` go to 0 asynchronously. The first tie after reset grants left.
